// File: rtl/async_input_conditioner_if.sv
// rtl/async_input_conditioner_if.sv - raw level in, conditioned level and edge strobes out
interface async_input_conditioner_if;
    logic async_in;
    logic level_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output async_in,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  async_in,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/async_input_conditioner.sv
// rtl/async_input_conditioner.sv - synchronizer plus debounce FSM with registered level and edge strobes
module async_input_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    async_input_conditioner_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_d, fall_d;
    logic                   level_q, rise_q, fall_q, busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.async_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (s) begin
                    if (DEBOUNCE_COUNT == 1) begin
                        state_d = STABLE_HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    if (DEBOUNCE_COUNT == 1) begin
                        state_d = STABLE_LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
        end
    end

    assign bus.level_out  = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_async_input_conditioner.sv
// tb/tb_async_input_conditioner.sv - directed bench, SYNC_STAGES=2 DEBOUNCE_COUNT=4
module tb_async_input_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rise_total = 0;
    int   fall_total = 0;
    int   violations = 0;
    logic prev_pulse = 1'b0;

    async_input_conditioner_if cond_if ();

    async_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_COUNT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cond_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cond_if.rise_pulse === 1'b1) rise_total++;
        if (cond_if.fall_pulse === 1'b1) fall_total++;
        if (cond_if.rise_pulse === 1'b1 && cond_if.fall_pulse === 1'b1) violations++;
        if ((cond_if.rise_pulse === 1'b1 || cond_if.fall_pulse === 1'b1) && prev_pulse) violations++;
        prev_pulse = (cond_if.rise_pulse === 1'b1) || (cond_if.fall_pulse === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector order: {level_out, rise_pulse, fall_pulse, busy}
    task automatic check4(input string tag, input logic [3:0] exp);
        logic [3:0] got;
        got = {cond_if.level_out, cond_if.rise_pulse, cond_if.fall_pulse, cond_if.busy};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    logic [3:0] glitch_exp [8];
    logic [3:0] rise_exp   [8];
    logic [3:0] fall_exp   [8];

    initial begin
        glitch_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        rise_exp   = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000, 4'b1000};
        fall_exp   = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000, 4'b0000};

        // Reset for two cycles, input low, then 20 quiet cycles
        cond_if.async_in = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check4("reset_state", 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check4($sformatf("idle_low[%0d]", i), 4'b0000);
        end

        // Two-cycle high glitch is rejected
        cond_if.async_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) cond_if.async_in = 1'b0;
            check4($sformatf("glitch[%0d]", i), glitch_exp[i]);
        end
        check_int("glitch_rise_count", rise_total, 0);

        // Held high qualifies after 6 edges with one rise strobe
        cond_if.async_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check4($sformatf("rise[%0d]", i), rise_exp[i]);
        end
        check_int("rise_count", rise_total, 1);
        check_int("fall_count_after_rise", fall_total, 0);

        // Held low from committed high qualifies after 6 edges with one fall strobe
        cond_if.async_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check4($sformatf("fall[%0d]", i), fall_exp[i]);
        end
        check_int("fall_count", fall_total, 1);
        check_int("rise_count_after_fall", rise_total, 1);

        // Toggle every cycle: level stays low, no strobes
        for (int i = 0; i < 50; i++) begin
            cond_if.async_in = ~cond_if.async_in;
            tick();
            check_bit($sformatf("toggle_level[%0d]", i), cond_if.level_out, 1'b0);
            check_bit($sformatf("toggle_pulse[%0d]", i), cond_if.rise_pulse | cond_if.fall_pulse, 1'b0);
        end
        cond_if.async_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check4("toggle_settled", 4'b0000);

        // Reset during WAIT_HIGH at cnt=2 aborts, then requalifies
        cond_if.async_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check4($sformatf("pre_abort[%0d]", i), rise_exp[i > 2 ? 2 : i]);
        end
        reset = 1'b1;
        tick();
        check4("abort_reset", 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check4($sformatf("post_abort[%0d]", i), rise_exp[i]);
        end

        check_int("total_rise", rise_total, 2);
        check_int("total_fall", fall_total, 1);
        check_int("pulse_rule_violations", violations, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/async_input_conditioner.md
ASYNC_INPUT_CONDITIONER -- requirements
Module: async_input_conditioner

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flip-flops (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_COUNT, default 16, meaning the consecutive equal synchronized samples required to commit a new level (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit; one clock, reset synchronous and active-high.
REQ-005 The block SHALL have port async_in, input, 1 bit, an unsynchronized level (switch or foreign-domain signal).
REQ-006 The block SHALL have port level_out, output, 1 bit, the debounced, synchronized level (registered).
REQ-007 The block SHALL have port rise_pulse, output, 1 bit, a one-cycle strobe on a committed 0->1 change (set request to a downstream SR latch).
REQ-008 The block SHALL have port fall_pulse, output, 1 bit, a one-cycle strobe on a committed 1->0 change (reset request).
REQ-009 The block SHALL have port busy, output, 1 bit, asserted while a candidate change is being qualified.

Function
REQ-010 async_in SHALL pass through a SYNC_STAGES-deep flip-flop chain; only the last stage output s SHALL be used by any other logic.
REQ-011 The FSM SHALL have states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW, plus a counter of ceil(log2(DEBOUNCE_COUNT+1)) bits.
REQ-012 In STABLE_LOW with s=1: if DEBOUNCE_COUNT=1, commit high immediately; otherwise go to WAIT_HIGH with cnt=1. With s=0: remain, cnt=0.
REQ-013 In WAIT_HIGH with s=0, the FSM SHALL return to STABLE_LOW with cnt=0 and generate no pulse (glitch rejected).
REQ-014 In WAIT_HIGH with s=1, cnt SHALL increment; on the edge where cnt+1 = DEBOUNCE_COUNT, the FSM SHALL enter STABLE_HIGH, set level_out=1, assert rise_pulse for exactly that following cycle, and clear cnt.
REQ-015 STABLE_HIGH/WAIT_LOW SHALL mirror REQ-012..014 with polarity inverted, producing fall_pulse.
REQ-016 Latency: with async_in held constant from the first sampling edge, level_out SHALL change after exactly SYNC_STAGES+DEBOUNCE_COUNT rising edges of clk.
REQ-017 rise_pulse and fall_pulse SHALL never be asserted in the same cycle and SHALL never be asserted in consecutive cycles for DEBOUNCE_COUNT>1.
REQ-018 busy SHALL equal 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
REQ-019 A change and its reversal within fewer than DEBOUNCE_COUNT synchronized samples SHALL leave level_out unchanged and generate no pulse.
REQ-020 The counter SHALL not wrap; it SHALL be cleared on every commit and every rejection.
REQ-021 All outputs SHALL be driven from registers (no combinational path from async_in).

Reset
REQ-022 While reset=1 at a clock edge, all synchronizer stages SHALL load 0, the state SHALL become STABLE_LOW, cnt=0, and level_out=rise_pulse=fall_pulse=busy=0.
REQ-023 Reset asserted during WAIT_HIGH or WAIT_LOW SHALL abort qualification with no pulse; reset has priority over every transition.
REQ-024 After reset deasserts with async_in=1, the block SHALL qualify high per REQ-016 and emit one rise_pulse.

Verification (bench with SYNC_STAGES=2, DEBOUNCE_COUNT=4)
REQ-025 reset=1 for 2 cycles, async_in=0 -> all outputs 0 and remain 0 for 20 cycles after release.
REQ-026 async_in 0->1 held -> level_out=1 after 6 edges, rise_pulse high for exactly 1 cycle, busy high for the 3 preceding cycles.
REQ-027 async_in high 2 cycles, then low (glitch) -> level_out stays 0, no pulses, busy returns to 0.
REQ-028 From level_out=1, async_in 1->0 held -> level_out=0 after 6 edges, one fall_pulse, no rise_pulse.
REQ-029 async_in toggling every cycle for 50 cycles -> no pulses, level_out constant.
REQ-030 reset=1 asserted mid-WAIT_HIGH (cnt=2) -> next cycle all outputs 0, no rise_pulse; async_in still 1 after release -> rise_pulse 6 edges later.
